// File: rtl/decode_sequencer.sv
// Decode-stage controller: decodes fetched RISC-V instructions into uops, buffers them in a
// small in-order FIFO for rename, and serializes BREAK/MONITOR around an empty ROB.

`ifndef M_WIDTH
`define M_WIDTH 32
`endif
`ifndef LG_PHT_SZ
`define LG_PHT_SZ 8
`endif

package decode_pkg;

  typedef enum logic [3:0] {
    OP_ILLEGAL,
    OP_ALU_IMM,
    OP_ALU_REG,
    OP_LUI,
    OP_AUIPC,
    OP_JAL,
    OP_JALR,
    OP_BRANCH,
    OP_LOAD,
    OP_STORE,
    OP_FENCE,
    OP_BREAK,
    OP_MONITOR
  } op_t;

  typedef struct packed {
    op_t                   op;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic                  has_dst;
    logic [31:0]           imm;
    logic [31:0]           insn;
    logic [`M_WIDTH-1:0]   pc;
    logic                  pred;
    logic [`LG_PHT_SZ-1:0] pht_idx;
    logic [`M_WIDTH-1:0]   pred_target;
    logic                  serializing_op;
    logic                  must_restart;
  } uop_t;

endpackage

module decode_riscv
  import decode_pkg::*;
(
  input  logic [31:0]           insn,
  input  logic [`M_WIDTH-1:0]   pc,
  input  logic                  insn_pred,
  input  logic [`LG_PHT_SZ-1:0] pht_idx,
  input  logic [`M_WIDTH-1:0]   insn_pred_target,
  output uop_t                  uop
);

  logic [6:0]  opcode;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = insn[6:0];
  assign imm_i  = {{20{insn[31]}}, insn[31:20]};
  assign imm_s  = {{20{insn[31]}}, insn[31:25], insn[11:7]};
  assign imm_b  = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
  assign imm_u  = {insn[31:12], 12'b0};
  assign imm_j  = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};

  // NOTE: every field gets a default before the case so no path leaves uop unassigned (no latch).
  always_comb begin
    uop             = '0;
    uop.op          = OP_ILLEGAL;
    uop.insn        = insn;
    uop.pc          = pc;
    uop.pred        = insn_pred;
    uop.pht_idx     = pht_idx;
    uop.pred_target = insn_pred_target;
    uop.rd          = insn[11:7];
    uop.rs1         = insn[19:15];
    uop.rs2         = insn[24:20];
    uop.funct3      = insn[14:12];
    uop.funct7      = insn[31:25];
    case (opcode)
      7'b0010011: begin uop.op = OP_ALU_IMM; uop.imm = imm_i; uop.has_dst = (insn[11:7] != 5'd0); end
      7'b0110011: begin uop.op = OP_ALU_REG;                  uop.has_dst = (insn[11:7] != 5'd0); end
      7'b0110111: begin uop.op = OP_LUI;     uop.imm = imm_u; uop.has_dst = (insn[11:7] != 5'd0); end
      7'b0010111: begin uop.op = OP_AUIPC;   uop.imm = imm_u; uop.has_dst = (insn[11:7] != 5'd0); end
      7'b1101111: begin uop.op = OP_JAL;     uop.imm = imm_j; uop.has_dst = (insn[11:7] != 5'd0); end
      7'b1100111: begin uop.op = OP_JALR;    uop.imm = imm_i; uop.has_dst = (insn[11:7] != 5'd0); end
      7'b0000011: begin uop.op = OP_LOAD;    uop.imm = imm_i; uop.has_dst = (insn[11:7] != 5'd0); end
      7'b1100011: begin uop.op = OP_BRANCH;  uop.imm = imm_b; end
      7'b0100011: begin uop.op = OP_STORE;   uop.imm = imm_s; end
      7'b0001111: begin uop.op = OP_FENCE; end
      7'b1110011: begin
        // Only the two system ops the sequencer understands are legal; both serialize.
        if (insn == 32'h0000_0073) begin
          uop.op             = OP_BREAK;
          uop.imm            = imm_i;
          uop.serializing_op = 1'b1;
        end else if (insn == 32'h0010_0073) begin
          uop.op             = OP_MONITOR;
          uop.imm            = imm_i;
          uop.serializing_op = 1'b1;
          uop.must_restart   = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

module decode_sequencer
  import decode_pkg::*;
#(
  parameter int LG_Q_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  insn_valid,
  input  logic [31:0]           insn,
  input  logic [`M_WIDTH-1:0]   pc,
  input  logic                  insn_pred,
  input  logic [`LG_PHT_SZ-1:0] pht_idx,
  input  logic [`M_WIDTH-1:0]   insn_pred_target,
  output logic                  insn_ready,
  output logic                  uop_valid,
  output uop_t                  uop,
  input  logic                  uop_ready,
  input  logic                  rob_empty,
  input  logic                  serial_retired,
  output logic                  serial_busy,
  output logic [31:0]           stall_cycles
);

  localparam int                    DEPTH     = 1 << LG_Q_DEPTH;
  localparam logic [LG_Q_DEPTH:0]   DEPTH_CNT = (LG_Q_DEPTH + 1)'(DEPTH);
  localparam logic [LG_Q_DEPTH:0]   CNT_ONE   = (LG_Q_DEPTH + 1)'(1);
  localparam logic [LG_Q_DEPTH-1:0] PTR_ONE   = LG_Q_DEPTH'(1);

  typedef enum logic [1:0] {RUN, DRAIN, ISSUE, WAIT_RETIRE} state_t;

  state_t                 state, state_nxt;
  uop_t                   mem [DEPTH];
  uop_t                   dec_uop;
  uop_t                   head;
  logic [LG_Q_DEPTH-1:0]  rd_ptr, wr_ptr;
  logic [LG_Q_DEPTH:0]    count;
  logic                   full, empty, enq, deq;
  logic                   rob_empty_q;
  logic                   restart_q, restart_nxt;
  logic [31:0]            stall_q;

  decode_riscv u_decode (
    .insn             (insn),
    .pc               (pc),
    .insn_pred        (insn_pred),
    .pht_idx          (pht_idx),
    .insn_pred_target (insn_pred_target),
    .uop              (dec_uop)
  );

  assign full         = (count == DEPTH_CNT);
  assign empty        = (count == '0);
  assign head         = mem[rd_ptr];
  assign uop          = head;
  assign insn_ready   = !full && !flush && !reset;
  assign enq          = insn_valid && insn_ready;
  assign deq          = uop_valid && uop_ready;
  assign serial_busy  = (state != RUN);
  assign stall_cycles = stall_q;

  always_comb begin
    state_nxt   = state;
    restart_nxt = restart_q;
    uop_valid   = 1'b0;
    case (state)
      RUN: begin
        uop_valid = !empty && !head.serializing_op;
        if (!empty && head.serializing_op) state_nxt = DRAIN;
      end
      DRAIN: if (rob_empty_q) state_nxt = ISSUE;
      ISSUE: begin
        uop_valid = 1'b1;
        if (uop_ready) begin
          state_nxt   = WAIT_RETIRE;
          restart_nxt = head.must_restart;
        end
      end
      // A must_restart op can only be left through flush; serial_retired is ignored for it.
      WAIT_RETIRE: if (!restart_q && serial_retired) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
    if (flush || reset) begin
      uop_valid = 1'b0;
      state_nxt = RUN;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      restart_q   <= 1'b0;
      rob_empty_q <= 1'b0;
      stall_q     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      state       <= state_nxt;
      restart_q   <= restart_nxt;
      rob_empty_q <= rob_empty;
      if ((state == DRAIN || state == WAIT_RETIRE) && stall_q != 32'hFFFF_FFFF)
        stall_q <= stall_q + 32'd1;
      if (flush) begin
        count  <= '0;
        rd_ptr <= wr_ptr;
      end else begin
        if (enq) wr_ptr <= wr_ptr + PTR_ONE;
        if (deq) rd_ptr <= rd_ptr + PTR_ONE;
        case ({enq, deq})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: ;
        endcase
      end
    end
  end

  // NOTE: the uop storage is cleared on reset too, so nothing from before reset stays on uop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (enq) begin
      mem[wr_ptr] <= dec_uop;
    end
  end

endmodule

// File: tb/tb_decode_sequencer.sv
// Self-checking bench for decode_sequencer: decode table, directed serialization/flush/reset
// sequences, and randomized traffic against a queue-based reference model.

`ifndef M_WIDTH
`define M_WIDTH 32
`endif
`ifndef LG_PHT_SZ
`define LG_PHT_SZ 8
`endif

module tb_decode_sequencer;
  import decode_pkg::*;

  localparam logic [31:0] ADDI_I    = 32'h0010_0093;
  localparam logic [31:0] BREAK_I   = 32'h0000_0073;
  localparam logic [31:0] MONITOR_I = 32'h0010_0073;
  localparam int M_FLOW = 0, M_DRAIN = 1, M_OFFER = 2, M_WAIT = 3;

  logic                  clk = 1'b0;
  logic                  reset, flush, insn_valid, insn_pred, uop_ready, rob_empty, serial_retired;
  logic [31:0]           insn;
  logic [`M_WIDTH-1:0]   pc, insn_pred_target, next_pc;
  logic [`LG_PHT_SZ-1:0] pht_idx;
  logic                  insn_ready, uop_valid, serial_busy;
  uop_t                  uop;
  logic [31:0]           stall_cycles;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0]         insn;
    logic [`M_WIDTH-1:0] pc;
  } entry_t;

  typedef struct {
    logic [31:0] insn;
    op_t         op;
    logic [4:0]  rd;
    logic [31:0] imm;
    bit          ser;
    bit          rst;
  } vec_t;

  entry_t      mq[$];
  int          m_mode;
  bit          m_rob_seen, m_sticky;
  logic [31:0] m_stall;
  bit          exp_ready, exp_valid, last_acc, last_deq;
  int          n_acc, n_deq;
  vec_t        vecs[9];

  decode_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .insn_valid       (insn_valid),
    .insn             (insn),
    .pc               (pc),
    .insn_pred        (insn_pred),
    .pht_idx          (pht_idx),
    .insn_pred_target (insn_pred_target),
    .insn_ready       (insn_ready),
    .uop_valid        (uop_valid),
    .uop              (uop),
    .uop_ready        (uop_ready),
    .rob_empty        (rob_empty),
    .serial_retired   (serial_retired),
    .serial_busy      (serial_busy),
    .stall_cycles     (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit serial(input logic [31:0] i);
    return (i == BREAK_I) || (i == MONITOR_I);
  endfunction

  function automatic logic [31:0] addi_k(input int k);
    logic [11:0] imm;
    imm = 12'(k);
    return {imm, 5'd0, 3'd0, 5'd1, 7'h13};
  endfunction

  function automatic logic [31:0] rand_alu();
    logic [31:0] w;
    w = $urandom();
    return {w[31:7], (w[0] ? 7'h13 : 7'h33)};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_mode     = M_FLOW;
    m_rob_seen = 1'b0;
    m_sticky   = 1'b0;
    m_stall    = '0;
  endtask

  task automatic drive(input bit v, input logic [31:0] i, input bit rdy, input bit rob,
                       input bit ret, input bit fl);
    insn_valid       = v;
    insn             = i;
    pc               = next_pc;
    insn_pred        = next_pc[2];
    pht_idx          = `LG_PHT_SZ'(next_pc >> 2);
    insn_pred_target = next_pc ^ `M_WIDTH'(32'h100);
    next_pc          = next_pc + `M_WIDTH'(4);
    uop_ready        = rdy;
    rob_empty        = rob;
    serial_retired   = ret;
    flush            = fl;
  endtask

  // Expected outputs follow from the queue contents and the serialization phase.
  task automatic compare_outputs();
    exp_ready = (mq.size() < 4) && !flush;
    if (m_mode == M_FLOW) exp_valid = (mq.size() > 0) && !serial(mq[0].insn);
    else                  exp_valid = (m_mode == M_OFFER);
    if (flush) exp_valid = 1'b0;
    check("insn_ready", insn_ready, exp_ready);
    check("uop_valid", uop_valid, exp_valid);
    check("serial_busy", serial_busy, m_mode != M_FLOW);
    check("stall_cycles", stall_cycles, m_stall);
    if (exp_valid) begin
      check("uop.insn", uop.insn, mq[0].insn);
      check("uop.pc", uop.pc, mq[0].pc);
      check("uop.serializing_op", uop.serializing_op, serial(mq[0].insn));
    end
  endtask

  task automatic model_clock();
    bit acc, dq;
    acc = insn_valid && exp_ready;
    dq  = exp_valid && uop_ready;
    if ((m_mode == M_DRAIN || m_mode == M_WAIT) && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (flush) begin
      mq.delete();
      m_mode = M_FLOW;
    end else begin
      case (m_mode)
        M_FLOW:  if (mq.size() > 0 && serial(mq[0].insn)) m_mode = M_DRAIN;
        M_DRAIN: if (m_rob_seen) m_mode = M_OFFER;
        M_OFFER: if (dq) begin m_mode = M_WAIT; m_sticky = (mq[0].insn == MONITOR_I); end
        M_WAIT:  if (!m_sticky && serial_retired) m_mode = M_FLOW;
        default: ;
      endcase
      if (dq) void'(mq.pop_front());
      if (acc) mq.push_back('{insn, pc});
    end
    m_rob_seen = rob_empty;
    last_acc   = acc;
    last_deq   = dq;
  endtask

  task automatic cycle();
    #1 compare_outputs();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic run(input bit v, input logic [31:0] i, input bit rdy, input bit rob,
                     input bit ret, input bit fl);
    drive(v, i, rdy, rob, ret, fl);
    cycle();
    n_acc += int'(last_acc);
    n_deq += int'(last_deq);
  endtask

  initial begin
    vecs[0] = '{32'h0010_0093, OP_ALU_IMM, 5'd1,  32'h0000_0001, 1'b0, 1'b0};
    vecs[1] = '{32'hFFF3_0293, OP_ALU_IMM, 5'd5,  32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[2] = '{32'h1234_5137, OP_LUI,     5'd2,  32'h1234_5000, 1'b0, 1'b0};
    vecs[3] = '{32'h0020_81B3, OP_ALU_REG, 5'd3,  32'h0000_0000, 1'b0, 1'b0};
    vecs[4] = '{32'h0100_00EF, OP_JAL,     5'd1,  32'h0000_0010, 1'b0, 1'b0};
    vecs[5] = '{32'hFE00_0CE3, OP_BRANCH,  5'd25, 32'hFFFF_FFF8, 1'b0, 1'b0};
    vecs[6] = '{BREAK_I,       OP_BREAK,   5'd0,  32'h0000_0000, 1'b1, 1'b0};
    vecs[7] = '{MONITOR_I,     OP_MONITOR, 5'd0,  32'h0000_0001, 1'b1, 1'b1};
    vecs[8] = '{32'hFFFF_FFFF, OP_ILLEGAL, 5'd31, 32'h0000_0000, 1'b0, 1'b0};

    next_pc = `M_WIDTH'(32'h1000);
    reset   = 1'b1;
    drive(0, 32'h0, 0, 0, 0, 0);
    @(negedge clk);
    check("reset insn_ready", insn_ready, 1'b0);
    check("reset uop_valid", uop_valid, 1'b0);
    check("reset serial_busy", serial_busy, 1'b0);
    check("reset stall_cycles", stall_cycles, 32'h0);
    reset = 1'b0;
    model_reset();

    // Decode table: enqueue one instruction, inspect the head, then flush it away.
    foreach (vecs[k]) begin
      run(1, vecs[k].insn, 0, 1, 0, 0);
      drive(0, 32'h0, 0, 1, 0, 0);
      #1;
      check("dec.op", uop.op, vecs[k].op);
      check("dec.rd", uop.rd, vecs[k].rd);
      check("dec.imm", uop.imm, vecs[k].imm);
      check("dec.serializing_op", uop.serializing_op, vecs[k].ser);
      check("dec.must_restart", uop.must_restart, vecs[k].rst);
      cycle();
      run(0, 32'h0, 0, 1, 0, 1);
      run(0, 32'h0, 0, 1, 0, 0);
    end

    // Six ADDIs streamed with rename always ready; the first is not visible the cycle it is taken.
    n_acc = 0; n_deq = 0;
    drive(1, ADDI_I, 1, 0, 0, 0);
    #1 check("t1 no bypass", uop_valid, 1'b0);
    for (int c = 0; c < 10; c++) run(n_acc < 6, ADDI_I, 1, 0, 0, 0);
    check("t1 accepted", n_acc, 6);
    check("t1 emitted", n_deq, 6);

    // Back-pressure: only four fit, the fifth waits for a free slot.
    n_acc = 0; n_deq = 0;
    for (int c = 0; c < 6; c++) run(n_acc < 5, addi_k(n_acc + 1), 0, 0, 0, 0);
    check("t2 accepted while full", n_acc, 4);
    drive(1, addi_k(5), 0, 0, 0, 0);
    #1 check("t2 insn_ready full", insn_ready, 1'b0);
    for (int c = 0; c < 8; c++) run(n_acc < 5, addi_k(n_acc + 1), 1, 0, 0, 0);
    check("t2 accepted total", n_acc, 5);
    check("t2 emitted total", n_deq, 5);

    // BREAK behind two ADDIs with a busy ROB, one younger ADDI behind it.
    n_acc = 0;
    for (int c = 0; c < 6; c++) begin
      logic [31:0] seq_i;
      seq_i = (n_acc == 2) ? BREAK_I : addi_k(16 + n_acc);
      run(n_acc < 4, seq_i, 1, 0, 0, 0);
    end
    drive(0, 32'h0, 1, 1, 0, 0);
    #1 check("t3 drain uop_valid", uop_valid, 1'b0);
    check("t3 drain serial_busy", serial_busy, 1'b1);
    cycle();
    drive(0, 32'h0, 1, 1, 0, 0);
    #1 check("t3 rob+1 uop_valid", uop_valid, 1'b0);
    cycle();
    drive(0, 32'h0, 1, 1, 0, 0);
    #1 check("t3 rob+2 uop_valid", uop_valid, 1'b1);
    check("t3 rob+2 uop.insn", uop.insn, BREAK_I);
    cycle();
    run(0, 32'h0, 1, 1, 0, 0);
    run(0, 32'h0, 1, 1, 0, 0);
    drive(0, 32'h0, 1, 1, 0, 0);
    #1 check("t3 younger held", uop_valid, 1'b0);
    cycle();
    run(0, 32'h0, 1, 1, 1, 0);
    drive(0, 32'h0, 1, 1, 0, 0);
    #1 check("t3 younger issues", uop_valid, 1'b1);
    check("t3 younger uop.insn", uop.insn, addi_k(19));
    cycle();

    // MONITOR needs a flush to leave WAIT_RETIRE.
    run(1, MONITOR_I, 1, 1, 0, 0);
    for (int c = 0; c < 4; c++) run(0, 32'h0, 1, 1, 0, 0);
    run(0, 32'h0, 1, 1, 1, 0);
    drive(0, 32'h0, 1, 1, 0, 0);
    #1 check("t4 retire ignored", serial_busy, 1'b1);
    cycle();
    run(0, 32'h0, 1, 1, 0, 1);
    drive(0, 32'h0, 1, 1, 0, 0);
    #1 check("t4 after flush serial_busy", serial_busy, 1'b0);
    check("t4 after flush insn_ready", insn_ready, 1'b1);
    cycle();

    // Flush with three queued and an instruction presented in the flush cycle.
    n_acc = 0; n_deq = 0;
    for (int c = 0; c < 3; c++) run(1, addi_k(32 + c), 0, 1, 0, 0);
    drive(1, addi_k(99), 0, 1, 0, 1);
    #1 check("t5 flush insn_ready", insn_ready, 1'b0);
    check("t5 flush uop_valid", uop_valid, 1'b0);
    cycle();
    for (int c = 0; c < 3; c++) run(0, 32'h0, 1, 1, 0, 0);
    check("t5 nothing emitted", n_deq, 0);

    // Asynchronous reset in the middle of DRAIN.
    run(1, BREAK_I, 1, 0, 0, 0);
    for (int c = 0; c < 3; c++) run(0, 32'h0, 1, 0, 0, 0);
    check("t6 in drain", serial_busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("t6 async insn_ready", insn_ready, 1'b0);
    check("t6 async uop_valid", uop_valid, 1'b0);
    check("t6 async serial_busy", serial_busy, 1'b0);
    check("t6 async stall_cycles", stall_cycles, 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Saturation of the stall counter.
    force dut.stall_q = 32'hFFFF_FFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.stall_q;
    m_stall = 32'hFFFF_FFFE;
    run(1, BREAK_I, 1, 0, 0, 0);
    for (int c = 0; c < 5; c++) run(0, 32'h0, 1, 0, 0, 0);
    check("t6 stall saturated", stall_cycles, 32'hFFFF_FFFF);
    run(0, 32'h0, 1, 0, 0, 1);
    run(0, 32'h0, 1, 0, 0, 0);
    check("t6 flush keeps stall", stall_cycles, 32'hFFFF_FFFF);

    // Randomized traffic; the model follows flush, drain, issue and retirement rules.
    reset = 1'b1;
    #1 model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      int          r;
      logic [31:0] ri;
      r  = $urandom_range(0, 99);
      ri = (r < 3) ? BREAK_I : (r < 4) ? MONITOR_I : rand_alu();
      run($urandom_range(0, 9) < 7, ri, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
          $urandom_range(0, 9) < 2, $urandom_range(0, 99) < 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
